// File: rtl/conv_window_buffer.sv
// Streaming line buffer and KxK window generator for raster-order RGB pixels.
// Presents each full, non-wrapping neighbourhood with a valid/ready handshake.
module conv_window_buffer #(
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic signed [95:0]                            pixel_in,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][95:0] window_out,
  output logic                                          window_valid,
  input  logic                                          window_ready,
  output logic [$clog2(IMG_WIDTH)-1:0]                  win_x,
  output logic [$clog2(IMG_HEIGHT)-1:0]                 win_y
);

  localparam int unsigned K  = KERNEL_SIZE;
  localparam int unsigned XW = $clog2(IMG_WIDTH);
  localparam int unsigned YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_WIN  = XW'(KERNEL_SIZE - 1);
  localparam logic [YW-1:0] Y_WIN  = YW'(KERNEL_SIZE - 1);

  logic [XW-1:0]               col_q, col_d;
  logic [YW-1:0]               row_q, row_d;
  logic [XW-1:0]               x_q;
  logic [YW-1:0]               y_q;
  logic                        valid_q, valid_d;
  logic [K-1:0][K-1:0][95:0]   win_q, win_d;
  logic [K-1:0][95:0]          new_col;
  logic                        accept;

  // Line buffers hold pixel data only; never reset (stale rows are masked by row >= K-1).
  logic [95:0] line_buf_q [K-1][IMG_WIDTH];

  assign in_ready = !valid_q || window_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    new_col = '0;
    for (int unsigned r = 0; r < K - 1; r++) begin
      new_col[r] = line_buf_q[K-2-r][col_q];
    end
    new_col[K-1] = pixel_in;
  end

  always_comb begin
    win_d = '0;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
      win_d[r][K-1] = new_col[r];
    end
  end

  always_comb begin
    col_d   = col_q + 1'b1;
    row_d   = row_q;
    valid_d = (col_q >= X_WIN) && (row_q >= Y_WIN);
    if (col_q == X_LAST) begin
      col_d = '0;
      row_d = (row_q == Y_LAST) ? '0 : row_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf_q[0][col_q] <= pixel_in;
      for (int unsigned i = 1; i < K - 1; i++) begin
        line_buf_q[i][col_q] <= line_buf_q[i-1][col_q];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q   <= '0;
      row_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      win_q   <= '0;
    end else if (accept) begin
      col_q   <= col_d;
      row_q   <= row_d;
      x_q     <= col_q;
      y_q     <= row_q;
      valid_q <= valid_d;
      win_q   <= win_d;
    end else if (window_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign window_out   = win_q;
  assign window_valid = valid_q;
  assign win_x        = x_q;
  assign win_y        = y_q;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Scoreboard bench for conv_window_buffer: K=3 on an 8x4 image.
module tb_conv_window_buffer;

  localparam int K = 3;
  localparam int W = 8;
  localparam int H = 4;

  logic                      clk;
  logic                      reset;
  logic signed [95:0]        pixel_in;
  logic                      in_valid;
  logic                      in_ready;
  logic [K-1:0][K-1:0][95:0] window_out;
  logic                      window_valid;
  logic                      window_ready;
  logic [2:0]                win_x;
  logic [1:0]                win_y;

  conv_window_buffer #(
    .KERNEL_SIZE(K),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_in    (pixel_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .window_out  (window_out),
    .window_valid(window_valid),
    .window_ready(window_ready),
    .win_x       (win_x),
    .win_y       (win_y)
  );

  typedef struct {
    logic [K-1:0][K-1:0][95:0] w;
    int                        x;
    int                        y;
  } exp_t;

  exp_t exp_q[$];
  int   tests   = 0;
  int   errors  = 0;
  int   win_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0: {y, x, 8y+x}; mode 1: {-x, -y, -1}; mode 2: frame tag +100 on blue
  function automatic logic [95:0] pix(input int x, input int y, input int mode);
    logic [31:0] r, g, b;
    case (mode)
      1:       begin r = 32'(-x); g = 32'(-y); b = 32'hFFFF_FFFF; end
      2:       begin r = 32'(y);  g = 32'(x);  b = 32'(8 * y + x + 100); end
      default: begin r = 32'(y);  g = 32'(x);  b = 32'(8 * y + x); end
    endcase
    return {r, g, b};
  endfunction

  function automatic logic [K-1:0][K-1:0][95:0] exp_win(input int x, input int y, input int mode);
    logic [K-1:0][K-1:0][95:0] w;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[r][c] = pix(x - (K - 1) + c, y - (K - 1) + r, mode);
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    tests++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic chk_win(input string name, input logic [K-1:0][K-1:0][95:0] got,
                         input logic [K-1:0][K-1:0][95:0] expv);
    bit bad = 0;
    tests++;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        if (!bad && got[r][c] !== expv[r][c]) begin
          bad = 1;
          errors++;
          $display("FAIL %s: elem[%0d][%0d] got %h expected %h", name, r, c, got[r][c], expv[r][c]);
        end
  endtask

  // Monitor: a window is consumed at the edge following a negedge with valid && ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && window_valid && window_ready) begin
        win_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL unexpected_window: got window at x=%0d y=%0d, expected none", win_x, win_y);
        end else begin
          e = exp_q.pop_front();
          chk("win_x", 64'(win_x), 64'(e.x));
          chk("win_y", 64'(win_y), 64'(e.y));
          chk_win("win_data", window_out, e.w);
        end
      end
    end
  end

  task automatic send_frame(input int mode, input bit gaps, input bit bp, input int npix);
    exp_t e;
    bit   acc;
    int   x, y;
    for (int idx = 0; idx < npix; idx++) begin
      x = idx % W;
      y = idx / W;
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      pixel_in = pix(x, y, mode);
      acc = 0;
      for (int t = 0; t < 50 && !acc; t++) begin
        @(negedge clk);
        if (in_ready) begin
          acc = 1;
          if (x >= K - 1 && y >= K - 1) begin
            e.w = exp_win(x, y, mode);
            e.x = x;
            e.y = y;
            exp_q.push_back(e);
          end
        end
        @(posedge clk); #1;
      end
      if (!acc) begin
        tests++;
        errors++;
        $display("FAIL accept_timeout: pixel (%0d,%0d) not accepted, expected accept", x, y);
      end
      if (bp && x == 2 && y == 2) begin
        window_ready = 1'b0;
        in_valid     = 1'b1;
        pixel_in     = pix(3, 2, mode);
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("bp_in_ready", 64'(in_ready), 64'd0);
          chk("bp_valid", 64'(window_valid), 64'd1);
          chk("bp_win_x", 64'(win_x), 64'd2);
          chk_win("bp_win_data", window_out, exp_win(2, 2, mode));
          @(posedge clk); #1;
        end
        window_ready = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_frame(input string name, input int start_cnt, input int expected);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_count"}, 64'(win_cnt - start_cnt), 64'(expected));
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int start;
    reset        = 1'b0;
    in_valid     = 1'b0;
    window_ready = 1'b1;
    pixel_in     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(window_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_win_x", 64'(win_x), 64'd0);
    chk("rst_win_y", 64'(win_y), 64'd0);
    chk("rst_win_zero", 64'(window_out == '0), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;

    start = win_cnt;
    send_frame(0, 0, 0, W * H);
    finish_frame("s1", start, 12);

    start = win_cnt;
    send_frame(0, 0, 1, W * H);
    finish_frame("s2", start, 12);

    start = win_cnt;
    send_frame(2, 0, 0, W * H);
    finish_frame("s3", start, 12);

    start = win_cnt;
    send_frame(0, 1, 0, W * H);
    finish_frame("s4", start, 12);

    send_frame(0, 0, 0, 20);
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid", 64'(window_valid), 64'd0);
    chk("async_win_x", 64'(win_x), 64'd0);
    chk("async_win_y", 64'(win_y), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd1);
    chk("async_win_zero", 64'(window_out == '0), 64'd1);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk); #1;
    start = win_cnt;
    send_frame(0, 0, 0, W * H);
    finish_frame("s5", start, 12);

    start = win_cnt;
    send_frame(1, 0, 0, W * H);
    finish_frame("s6", start, 12);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv_window_buffer.md
# conv_window_buffer

Streaming line-buffer and window generator that feeds `kernel_convolution`. It accepts one signed 96-bit RGB pixel per handshake in raster order and keeps the last KERNEL_SIZE−1 image lines. On each pixel that completes a full, non-wrapping KERNEL_SIZE×KERNEL_SIZE neighbourhood, it presents that window with a valid/ready handshake. This block is the producer of the window array that the convolution datapath consumes.

## Interface
- KERNEL_SIZE, 3: window edge length K (≥2).
- IMG_WIDTH, 640: pixels per line (≥K).
- IMG_HEIGHT, 480: lines per frame (≥K).
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  reset, asynchronous and active-low: 0 resets, 1 runs.
- pixel_in  input  96  signed {r[31:0], g[31:0], b[31:0]}, each a 32-bit signed channel.
- in_valid  input  1  pixel_in is valid.
- in_ready  output  1  block can accept a pixel; a pixel is accepted when in_valid && in_ready.
- window_out  output  [K-1:0][K-1:0] × 96  window; [0][0] is top-left (oldest line, oldest column), [K-1][K-1] is the newest pixel.
- window_valid  output  1  window_out holds a complete window.
- window_ready  input  1  consumer takes the window.
- win_x  output  $clog2(IMG_WIDTH)  column of window_out[K-1][K-1].
- win_y  output  $clog2(IMG_HEIGHT)  line of window_out[K-1][K-1].

## Operation
- State:
  - col counter 0..IMG_WIDTH−1.
  - row counter 0..IMG_HEIGHT−1.
  - K−1 line buffers of IMG_WIDTH×96 bits, addressed by col.
  - K×K window register array.
  - window_valid flag.
- in_ready = !window_valid || window_ready. The combinational path from window_ready to in_ready is allowed.
- On accept at (col,row):
  - New column vector: element K−1 = pixel_in; element r (r<K−1) = line_buf[K−2−r][col], read before the write.
  - Line buffers shift at address col: line_buf[0] ← pixel_in, line_buf[i] ← line_buf[i−1].
  - Window registers shift one column left: column c ← column c+1, column K−1 ← new column vector.
  - win_x ← col, win_y ← row.
  - window_valid ← (col ≥ K−1) && (row ≥ K−1).
  - Counters advance in raster order. col wraps to 0 at IMG_WIDTH−1 and row increments. At (IMG_WIDTH−1, IMG_HEIGHT−1) both wrap to 0, and the next pixel is (0,0) of a new frame.
- No accept and window_ready=1: window_valid ← 0.
- No accept and window_ready=0: all outputs hold.
- Windows never straddle a line boundary. Columns shifted in from the previous line are present only while col < K−1, and window_valid is 0 there.
- Line-buffer contents are not reset. Stale contents are never exposed because row ≥ K−1 is required.
- Windows per frame: (IMG_HEIGHT−K+1)·(IMG_WIDTH−K+1).
- Data is passed through unmodified; no arithmetic on pixels.

## Timing
- Reset (reset=0, asynchronous): col=0, row=0, window_valid=0, window_out all 0, win_x=0, win_y=0, in_ready=1.
- Reset mid-frame discards the frame. The first pixel after release is (0,0).
- Latency: window_valid rises on the clock edge that accepts the completing pixel. window_out, win_x and win_y are valid from that edge, i.e. one cycle after the pixel is presented.
- Throughput: one pixel per cycle with in_valid=1 and window_ready=1.
- Backpressure: while window_valid=1 and window_ready=0, in_ready=0 and window_out, win_x, win_y are stable.
- Accept and window_ready in the same cycle: the current window is consumed and the next window (or window_valid=0) loads on the same edge.
- in_valid gaps: no state change except the window_valid clear when window_ready=1.

## Test plan
Defaults for all scenarios: K=3, IMG_WIDTH=8, IMG_HEIGHT=4; pixel (x,y) = {y, x, 8y+x}.

1. Reset, then stream 32 pixels back-to-back with window_ready=1.
   - First window_valid follows accept of pixel 18 (x=2, y=2): window_out[0][0]=(0,0), [0][2]=(2,0), [2][0]=(0,2), [2][2]=(2,2), win_x=2, win_y=2.
   - Exactly 12 windows total.
   - window_valid=0 for x∈{0,1} on every line.
2. Hold window_ready=0 after the first window for 5 cycles with in_valid=1.
   - in_ready=0 for all 5 cycles; window_out and win_x=2 stay stable; no pixel is lost.
   - After window_ready=1, the next window has win_x=3, win_y=2 with [2][2]=(3,2).
3. Stream two consecutive frames.
   - Frame 2 yields 12 windows; its first window is again (x=2, y=2).
   - Its top rows contain frame 2 data only, not frame 1 data.
4. Insert random in_valid gaps (50% duty) across a frame.
   - Window sequence and contents are identical to scenario 1.
5. Assert reset=0 asynchronously mid-cycle at pixel 20, then restart the frame from (0,0).
   - Outputs go to reset values immediately, without waiting for a clock edge.
   - Full-frame results are identical to scenario 1.
6. Negative channels: pixel = {−x, −y, −1}.
   - window_out reproduces the values bit-exact, sign preserved.
